// File: rtl/difftest_pkg.sv
// Shared types and helpers for the difftest commit-trace buffer.
package difftest_pkg;

  // Width of pc and write data carried by one commit record.
  parameter int XLEN = 64;

  // Widest in_valid vector that popcount handles.
  localparam int MAX_LANES = 16;
  localparam int POP_W     = $clog2(MAX_LANES + 1);

  // One retired instruction as seen by the difftest debug interface.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      reg_num;
    logic [XLEN-1:0] wdata;
  } commit_t;

  // Number of set bits in a lane-valid vector.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [POP_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      sum = sum + POP_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/commit_compactor.sv
// Turns a sparse per-lane valid vector into a record count and a dense slot
// offset per lane, so valid lanes land in consecutive FIFO entries in
// program order regardless of holes.
module commit_compactor #(
  parameter int NCOMMIT = 2,
  parameter int NW      = $clog2(NCOMMIT + 1)
) (
  input  logic [NCOMMIT-1:0] in_valid,
  output logic [NW-1:0]      n,
  output logic [NW-1:0]      offset [NCOMMIT]
);
  import difftest_pkg::*;

  logic [NW-1:0] run;

  // Exclusive prefix sum: a lane's slot is the number of valid older lanes.
  always_comb begin
    // NOTE: blocking assignments here are intentional; the running sum must be
    // visible to the next loop iteration within the same evaluation.
    run = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      offset[i] = run;
      run       = run + NW'(in_valid[i]);
    end
  end

  // Total records offered this cycle.
  always_comb begin
    n = NW'(popcount(MAX_LANES'(in_valid)));
  end

endmodule

// File: rtl/difftest_commit_buffer.sv
// Commit-trace buffer: compacts up to NCOMMIT retirements per cycle into a
// circular FIFO and drains one record per cycle to the single-lane difftest
// interface. Pushes offered while the FIFO lacks NCOMMIT free slots are
// dropped whole and latch a sticky overflow flag.
module difftest_commit_buffer #(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 64,
  parameter int DEPTH   = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NCOMMIT-1:0]         in_valid,
  input  logic [NCOMMIT*XLEN-1:0]    in_pc,
  input  logic [NCOMMIT*5-1:0]       in_reg_num,
  input  logic [NCOMMIT*XLEN-1:0]    in_wdata,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_reg_num,
  output logic [XLEN-1:0]            out_wdata,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  import difftest_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(NCOMMIT + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  commit_t       mem [DEPTH];
  commit_t       lane_rec [NCOMMIT];
  commit_t       head;
  logic [NW-1:0] n_valid;
  logic [NW-1:0] n_acc;
  logic [NW-1:0] lane_offset [NCOMMIT];
  logic          push_en;
  logic          pop;

  commit_compactor #(
    .NCOMMIT (NCOMMIT),
    .NW      (NW)
  ) u_compactor (
    .in_valid (in_valid),
    .n        (n_valid),
    .offset   (lane_offset)
  );

  // Unpack the flat lane buses into records.
  always_comb begin
    for (int i = 0; i < NCOMMIT; i++) begin
      lane_rec[i].pc      = in_pc[i*XLEN +: XLEN];
      lane_rec[i].reg_num = in_reg_num[i*5 +: 5];
      lane_rec[i].wdata   = in_wdata[i*XLEN +: XLEN];
    end
  end

  // Handshake and next-state: in_ready depends on registered count only, so
  // there is no combinational path from out_ready to in_ready.
  always_comb begin
    in_ready   = (count_q <= CW'(DEPTH - NCOMMIT));
    out_valid  = (count_q != '0);
    push_en    = in_ready;
    pop        = out_valid && out_ready;
    n_acc      = push_en ? n_valid : '0;
    wr_ptr_d   = wr_ptr_q + PW'(n_acc);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(n_acc) - CW'(pop);
    overflow_d = overflow_q || ((|in_valid) && !in_ready);
  end

  // Control state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage: each accepted lane goes to wr_ptr plus its compacted slot.
  // NOTE: the array has no reset; an entry is only read once count says it was
  // written, so clearing it would cost a reset net for no behavioural gain.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NCOMMIT; i++) begin
      if (push_en && in_valid[i]) begin
        mem[wr_ptr_q + PW'(lane_offset[i])] <= lane_rec[i];
      end
    end
  end

  // Head read; data is forced to zero while nothing is buffered.
  always_comb begin
    head        = mem[rd_ptr_q];
    out_pc      = out_valid ? head.pc      : '0;
    out_reg_num = out_valid ? head.reg_num : '0;
    out_wdata   = out_valid ? head.wdata   : '0;
    count       = count_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Directed self-checking bench for difftest_commit_buffer (NCOMMIT=2, XLEN=64,
// DEPTH=8). Inputs change 1 time unit after the rising edge; outputs are
// checked at that same point, well clear of the next edge.
module tb_difftest_commit_buffer;

  localparam int NCOMMIT = 2;
  localparam int XLEN    = 64;
  localparam int DEPTH   = 8;

  logic                    aclk;
  logic                    aresetn;
  logic [NCOMMIT-1:0]      in_valid;
  logic [NCOMMIT*XLEN-1:0] in_pc;
  logic [NCOMMIT*5-1:0]    in_reg_num;
  logic [NCOMMIT*XLEN-1:0] in_wdata;
  logic                    in_ready;
  logic                    out_valid;
  logic [XLEN-1:0]         out_pc;
  logic [4:0]              out_reg_num;
  logic [XLEN-1:0]         out_wdata;
  logic                    out_ready;
  logic [3:0]              count;
  logic                    overflow;

  int n_cmp = 0;
  int n_err = 0;

  difftest_commit_buffer #(
    .NCOMMIT (NCOMMIT),
    .XLEN    (XLEN),
    .DEPTH   (DEPTH)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_reg_num  (in_reg_num),
    .in_wdata    (in_wdata),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_reg_num (out_reg_num),
    .out_wdata   (out_wdata),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [63:0] pc, input logic [4:0] rn,
                          input logic [63:0] wd);
    in_pc[i*XLEN +: XLEN]   = pc;
    in_reg_num[i*5 +: 5]    = rn;
    in_wdata[i*XLEN +: XLEN] = wd;
  endtask

  // Reset with random inputs, checked while reset is still asserted.
  task automatic test_reset();
    aresetn    = 1'b0;
    in_valid   = NCOMMIT'($urandom);
    in_pc      = {$urandom, $urandom, $urandom, $urandom};
    in_reg_num = 10'($urandom);
    in_wdata   = {$urandom, $urandom, $urandom, $urandom};
    out_ready  = 1'($urandom);
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %0b want 0", overflow); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_pc !== 64'd0 || out_reg_num !== 5'd0 || out_wdata !== 64'd0) begin
      n_err++; $display("FAIL rst_out_data got pc=%h rn=%0d wd=%h want zeros", out_pc, out_reg_num, out_wdata);
    end
    @(posedge aclk);
    #1;
    in_valid  = '0;
    out_ready = 1'b0;
    aresetn   = 1'b1;
    #1;
  endtask

  // Two lanes in one cycle, drained in lane order on consecutive cycles.
  task automatic test_dual_push();
    set_lane(0, 64'h8000_0000, 5'd1, 64'h1111);
    set_lane(1, 64'h8000_0004, 5'd2, 64'h2222);
    in_valid  = 2'b11;
    out_ready = 1'b1;
    step();
    in_valid = 2'b00;
    n_cmp++; if (out_pc !== 64'h8000_0000) begin n_err++; $display("FAIL dual_first_pc got %h want 80000000", out_pc); end
    n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL dual_count2 got %0d want 2", count); end
    n_cmp++; if (out_wdata !== 64'h1111 || out_reg_num !== 5'd1) begin
      n_err++; $display("FAIL dual_first_data got rn=%0d wd=%h want rn=1 wd=1111", out_reg_num, out_wdata);
    end
    step();
    n_cmp++; if (out_pc !== 64'h8000_0004) begin n_err++; $display("FAIL dual_second_pc got %h want 80000004", out_pc); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL dual_count1 got %0d want 1", count); end
    step();
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL dual_empty got count=%0d valid=%0b want 0/0", count, out_valid);
    end
    n_cmp++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL dual_empty_pc got %h want 0", out_pc); end
    out_ready = 1'b0;
  endtask

  // Only lane 1 valid: one record, compacted into the head slot; reg 0 kept.
  task automatic test_hole();
    set_lane(0, 64'hdead_beef, 5'd3, 64'hbad);
    set_lane(1, 64'h8000_0010, 5'd0, 64'h5a5a);
    in_valid = 2'b10;
    step();
    in_valid = 2'b00;
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL hole_count got %0d want 1", count); end
    n_cmp++; if (out_pc !== 64'h8000_0010) begin n_err++; $display("FAIL hole_pc got %h want 80000010", out_pc); end
    n_cmp++; if (out_reg_num !== 5'd0 || out_wdata !== 64'h5a5a || out_valid !== 1'b1) begin
      n_err++; $display("FAIL hole_data got v=%0b rn=%0d wd=%h want 1/0/5a5a", out_valid, out_reg_num, out_wdata);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL hole_drain got %0d want 0", count); end
  endtask

  // Fill to capacity, drop a push, then drain and confirm nothing was overwritten.
  task automatic test_fill_backpressure();
    logic [63:0] base;
    base = 64'h8000_0100;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_lane(0, base + 64'(8*k),     5'(k), 64'(k));
      set_lane(1, base + 64'(8*k + 4), 5'(k), 64'(k));
      in_valid = 2'b11;
      step();
      if (k == 2) begin
        n_cmp++; if (count !== 4'd6 || in_ready !== 1'b1) begin
          n_err++; $display("FAIL fill_six got count=%0d rdy=%0b want 6/1", count, in_ready);
        end
      end
    end
    n_cmp++; if (count !== 4'd8 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_full got count=%0d rdy=%0b want 8/0", count, in_ready);
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_no_ovf got %0b want 0", overflow); end
    set_lane(0, 64'hffff_0000, 5'd9, 64'h9);
    set_lane(1, 64'hffff_0004, 5'd9, 64'h9);
    in_valid = 2'b11;
    step();
    in_valid = 2'b00;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL drop_count got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_overflow got %0b want 1", overflow); end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_cmp++; if (out_pc !== base + 64'(4*j)) begin
        n_err++; $display("FAIL drain_pc[%0d] got %h want %h", j, out_pc, base + 64'(4*j));
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 4'd0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL drain_end got count=%0d ovf=%0b want 0/1", count, overflow);
    end
  endtask

  // Interleaved push/pop across pointer wrap, checked against a queue model.
  task automatic test_wrap();
    logic [63:0] exp_q [$];
    logic [63:0] next_pc;
    int          mcount;
    logic        exp_ready;
    logic        do_pop;
    next_pc = 64'h8000_1000;
    // One single-lane push first so later pairs straddle the wrap point.
    set_lane(0, next_pc, 5'd7, 64'd0);
    in_valid = 2'b01;
    exp_q.push_back(next_pc);
    next_pc += 4;
    mcount = 1;
    step();
    for (int c = 0; c < 20; c++) begin
      out_ready = 1'(c % 2);
      exp_ready = ((DEPTH - mcount) >= NCOMMIT);
      n_cmp++; if (in_ready !== exp_ready || out_valid !== (mcount != 0)) begin
        n_err++; $display("FAIL wrap_hs[%0d] got rdy=%0b v=%0b want %0b/%0b", c, in_ready, out_valid, exp_ready, mcount != 0);
      end
      do_pop = out_ready && (mcount != 0);
      if (do_pop) begin
        n_cmp++; if (out_pc !== exp_q[0]) begin
          n_err++; $display("FAIL wrap_pc[%0d] got %h want %h", c, out_pc, exp_q[0]);
        end
        void'(exp_q.pop_front());
        mcount--;
      end
      if (exp_ready) begin
        set_lane(0, next_pc,     5'd1, 64'd0);
        set_lane(1, next_pc + 4, 5'd2, 64'd0);
        exp_q.push_back(next_pc);
        exp_q.push_back(next_pc + 4);
        next_pc += 8;
        mcount += 2;
        in_valid = 2'b11;
      end else begin
        in_valid = 2'b00;
      end
      step();
    end
    in_valid  = 2'b00;
    out_ready = 1'b1;
    n_cmp++; if (count !== 4'(mcount)) begin n_err++; $display("FAIL wrap_count got %0d want %0d", count, mcount); end
    while (exp_q.size() > 0) begin
      n_cmp++; if (out_pc !== exp_q[0]) begin
        n_err++; $display("FAIL wrap_tail got %h want %h", out_pc, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 4'd0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL wrap_end got count=%0d ovf=%0b want 0/0", count, overflow);
    end
  endtask

  // Asynchronous reset with five records buffered, then normal operation.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_lane(0, 64'h8000_2000, 5'd1, 64'd1);
    set_lane(1, 64'h8000_2004, 5'd2, 64'd2);
    in_valid = 2'b11; step();
    in_valid = 2'b11; step();
    in_valid = 2'b01; step();
    in_valid = 2'b00;
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL mid_pre_count got %0d want 5", count); end
    #2;
    aresetn = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_async got count=%0d v=%0b want 0/0", count, out_valid);
    end
    step();
    aresetn = 1'b1;
    set_lane(0, 64'h8000_3000, 5'd4, 64'h44);
    in_valid = 2'b01;
    step();
    in_valid = 2'b00;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_3000 || count !== 4'd1) begin
      n_err++; $display("FAIL mid_repush got v=%0b pc=%h cnt=%0d want 1/80003000/1", out_valid, out_pc, count);
    end
  endtask

  initial begin
    aresetn    = 1'b0;
    in_valid   = '0;
    in_pc      = '0;
    in_reg_num = '0;
    in_wdata   = '0;
    out_ready  = 1'b0;
    test_reset();
    test_dual_push();
    test_hole();
    test_fill_backpressure();
    test_reset();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
